// File: rtl/seg7_scan_driver_if.sv
// Display-side signal bundle for the 4-digit multiplexed 7-segment scan driver.
// The master drives digit data and controls; the slave (the driver) returns the pin-level outputs.
interface seg7_scan_driver_if;
  logic        enable;
  logic [15:0] bcd_in;
  logic [3:0]  dp_mask;
  logic        blank_lz;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  modport master (
    output enable, bcd_in, dp_mask, blank_lz,
    input  seg_n, dp_n, an_n, frame_done
  );

  modport slave (
    input  enable, bcd_in, dp_mask, blank_lz,
    output seg_n, dp_n, an_n, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display showing SS:ss BCD.
// Each digit slot starts with an anodes-off guard interval to avoid ghosting between digits.
module seg7_scan_driver #(
  parameter int DIGIT_TICK   = 100_000,
  parameter int GUARD_CYCLES = 4
) (
  input logic               clk,
  input logic               resetn,
  seg7_scan_driver_if.slave disp
);

  localparam int CW = $clog2(DIGIT_TICK);

  logic [1:0]    sync_ff;
  logic          rst_ok;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   sh_bcd;
  logic [3:0]    sh_dp;
  logic          started;

  logic          run;
  logic          tc;
  logic          frame_end;
  logic          load;
  logic [15:0]   cur_bcd;
  logic [3:0]    cur_dp;
  logic [3:0]    digit;

  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic          fd_q;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // Reset asserts immediately but is released only after two clean clock edges.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_ff <= 2'b00;
    else         sync_ff <= {sync_ff[0], 1'b1};
  end

  assign rst_ok    = sync_ff[1];
  assign run       = disp.enable && rst_ok;
  assign tc        = (cnt == CW'(DIGIT_TICK - 1));
  assign frame_end = tc && (idx == 2'd3);
  assign load      = !started || frame_end;

  // Until the first load after (re)enable the shadows are stale, so bypass them.
  assign cur_bcd = started ? sh_bcd : disp.bcd_in;
  assign cur_dp  = started ? sh_dp  : disp.dp_mask;

  always_comb begin
    digit = cur_bcd[3:0];
    case (idx)
      2'd0:    digit = cur_bcd[3:0];
      2'd1:    digit = cur_bcd[7:4];
      2'd2:    digit = cur_bcd[11:8];
      default: digit = cur_bcd[15:12];
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      idx     <= 2'd0;
      sh_bcd  <= 16'h0000;
      sh_dp   <= 4'h0;
      started <= 1'b0;
    end else if (!run) begin
      cnt     <= '0;
      idx     <= 2'd0;
      started <= 1'b0;
    end else begin
      cnt     <= tc ? '0 : cnt + CW'(1);
      if (tc) idx <= idx + 2'd1;
      if (load) begin
        sh_bcd <= disp.bcd_in;
        sh_dp  <= disp.dp_mask;
      end
      started <= 1'b1;
    end
  end

  always_comb begin
    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (run && (cnt >= CW'(GUARD_CYCLES))) begin
      an_d = ~(4'b0001 << idx);
      if (disp.blank_lz && (idx == 2'd3) && (digit == 4'd0)) begin
        seg_d = 7'h7F;
        dp_d  = 1'b1;
      end else begin
        seg_d = seg_decode(digit);
        dp_d  = ~cur_dp[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      an_q  <= 4'hF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
      fd_q  <= 1'b0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      fd_q  <= run && frame_end;
    end
  end

  assign disp.an_n       = an_q;
  assign disp.seg_n      = seg_q;
  assign disp.dp_n       = dp_q;
  assign disp.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: expected {an_n, seg_n, dp_n, frame_done} per cycle are
// queued as stimulus is applied and compared against the DUT on each falling clock edge.
module tb_seg7_scan_driver;

  localparam int TICK  = 8;
  localparam int GUARD = 2;
  localparam int FRAME = 4 * TICK;
  localparam logic [12:0] BLANK = {4'hF, 7'h7F, 1'b1, 1'b0};

  logic clk    = 1'b0;
  logic resetn = 1'b1;

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(
    .DIGIT_TICK  (TICK),
    .GUARD_CYCLES(GUARD)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .disp  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] observed();
    return {bus.an_n, bus.seg_n, bus.dp_n, bus.frame_done};
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'h40;  4'd1: s = 7'h79;  4'd2: s = 7'h24;  4'd3: s = 7'h30;
      4'd4: s = 7'h19;  4'd5: s = 7'h12;  4'd6: s = 7'h02;  4'd7: s = 7'h78;
      4'd8: s = 7'h00;  4'd9: s = 7'h10;  default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // Expected pins for position k within a frame: slot k/TICK, slot cycle k%TICK.
  function automatic logic [12:0] exp_entry(input logic [15:0] bcd, input logic [3:0] dpm,
                                            input logic blz, input int k);
    int idx;
    int cnt;
    logic [3:0] dig;
    logic [3:0] an;
    logic [6:0] seg;
    logic dp;
    logic fd;
    idx = (k % FRAME) / TICK;
    cnt = k % TICK;
    fd  = (idx == 3) && (cnt == TICK - 1);
    if (cnt < GUARD) return {4'hF, 7'h7F, 1'b1, fd};
    dig = bcd[idx*4 +: 4];
    an  = 4'hF;
    an[idx] = 1'b0;
    seg = seg_of(dig);
    dp  = ~dpm[idx];
    if (blz && idx == 3 && dig == 4'd0) begin
      seg = 7'h7F;
      dp  = 1'b1;
    end
    return {an, seg, dp, fd};
  endfunction

  task automatic checkOutput(input string tag, input logic [12:0] got, input logic [12:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got an_n=%b seg_n=%h dp_n=%b fd=%b, expected an_n=%b seg_n=%h dp_n=%b fd=%b",
               tag, got[12:9], got[8:2], got[1], got[0], want[12:9], want[8:2], want[1], want[0]);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [15:0] bcd, input logic [3:0] dpm,
                               input logic blz);
    bus.enable   = en;
    bus.bcd_in   = bcd;
    bus.dp_mask  = dpm;
    bus.blank_lz = blz;
  endtask

  task automatic push_entries(input logic [15:0] bcd, input logic [3:0] dpm, input logic blz,
                              input int first, input int n);
    for (int k = first; k < first + n; k++) exp_q.push_back(exp_entry(bcd, dpm, blz, k));
  endtask

  task automatic push_blank(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(BLANK);
  endtask

  task automatic run_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) checkOutput($sformatf("%s_noexp[%0d]", tag, i), 13'(exp_q.size()), 13'd1);
      else                   checkOutput($sformatf("%s[%0d]", tag, i), observed(), exp_q.pop_front());
    end
  endtask

  initial begin
    applyStimulus(1'b0, 16'h1234, 4'b0100, 1'b0);
    #2 resetn = 1'b0;
    #1 checkOutput("reset_async", observed(), BLANK);
    repeat (3) @(negedge clk);
    checkOutput("reset_hold", observed(), BLANK);

    // Release with enable high: two synchroniser cycles, then two frames of 1234.
    applyStimulus(1'b1, 16'h1234, 4'b0100, 1'b0);
    resetn = 1'b1;
    push_blank(2);
    push_entries(16'h1234, 4'b0100, 1'b0, 0, FRAME + 11);
    run_cycles("f1234", 2 + FRAME + 11);

    // New value arrives while digit 1 is showing; must wait for the frame boundary.
    applyStimulus(1'b1, 16'h5678, 4'b0100, 1'b0);
    push_entries(16'h1234, 4'b0100, 1'b0, 11, FRAME - 11);
    push_entries(16'h5678, 4'b0100, 1'b0, 0, FRAME - 1);
    run_cycles("f5678", 2 * FRAME - 12);

    // Enable drops on the terminal cycle of digit 3: no frame_done, blank outputs.
    applyStimulus(1'b0, 16'h5678, 4'b0100, 1'b0);
    push_blank(2);
    run_cycles("en_drop_tc", 2);

    applyStimulus(1'b1, 16'h0512, 4'b0000, 1'b1);
    push_entries(16'h0512, 4'b0000, 1'b1, 0, FRAME);
    run_cycles("lz_on", FRAME);
    applyStimulus(1'b0, 16'h0512, 4'b0000, 1'b1);
    push_blank(1);
    run_cycles("off1", 1);

    applyStimulus(1'b1, 16'h0512, 4'b0000, 1'b0);
    push_entries(16'h0512, 4'b0000, 1'b0, 0, FRAME);
    run_cycles("lz_off", FRAME);
    applyStimulus(1'b0, 16'h0512, 4'b0000, 1'b0);
    push_blank(1);
    run_cycles("off2", 1);

    // Dash codes, then a reset pulse in the middle of digit 2's lit time.
    applyStimulus(1'b1, 16'hA9F0, 4'b1001, 1'b0);
    push_entries(16'hA9F0, 4'b1001, 1'b0, 0, FRAME + 2 * TICK + 4);
    run_cycles("dash", FRAME + 2 * TICK + 4);
    resetn = 1'b0;
    #1 checkOutput("reset_mid_async", observed(), BLANK);
    repeat (2) @(negedge clk);
    checkOutput("reset_mid_hold", observed(), BLANK);
    resetn = 1'b1;
    push_blank(2);
    push_entries(16'hA9F0, 4'b1001, 1'b0, 0, FRAME);
    run_cycles("after_reset", 2 + FRAME);

    checkOutput("queue_drained", 13'(exp_q.size()), 13'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
